// File: rtl/register_file_pkg.sv
// register_file_pkg: ISA-fixed widths and flag-word bit positions for the
// architectural register file, plus the flag packing helper.
// Revision: 1.0
`default_nettype none

package register_file_pkg;

    localparam int DATA_W   = 16;
    localparam int PAGE_W   = 4;
    localparam int INT_W    = 9;
    localparam int CMP_W    = 3;

    localparam int PAGE_MSB = 15;
    localparam int PAGE_LSB = 12;
    localparam int INT_MSB  = 11;
    localparam int INT_LSB  = 3;
    localparam int CMP_MSB  = 2;
    localparam int CMP_LSB  = 0;

    function automatic logic [DATA_W-1:0] pack_flags(
        input logic [PAGE_W-1:0] page,
        input logic [INT_W-1:0]  intr,
        input logic [CMP_W-1:0]  cmp
    );
        logic [DATA_W-1:0] f;
        f                   = '0;
        f[PAGE_MSB:PAGE_LSB] = page;
        f[INT_MSB:INT_LSB]   = intr;
        f[CMP_MSB:CMP_LSB]   = cmp;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_file_if.sv
// register_file_if: control-unit write port and register readout bundle.
// Revision: 1.0
`default_nettype none

interface register_file_if;
    import register_file_pkg::*;

    logic [DATA_W-1:0] r_input;
    logic              r_write;
    logic              r_backup;
    logic              r_restore;
    logic [PAGE_W-1:0] page_input;
    logic              page_write;
    logic [CMP_W-1:0]  compare_input;
    logic              compare_write;
    logic [DATA_W-1:0] stack_pointer_input;
    logic              stack_pointer_write;
    logic [DATA_W-1:0] return_address_input;
    logic              return_address_write;
    logic [INT_W-1:0]  interrupt_input;
    logic              interrupt_write;

    logic [DATA_W-1:0] r_output;
    logic [DATA_W-1:0] flag_output;
    logic [DATA_W-1:0] stack_pointer_output;
    logic [DATA_W-1:0] return_address_output;

    modport master (
        output r_input, r_write, r_backup, r_restore,
        output page_input, page_write, compare_input, compare_write,
        output stack_pointer_input, stack_pointer_write,
        output return_address_input, return_address_write,
        output interrupt_input, interrupt_write,
        input  r_output, flag_output, stack_pointer_output, return_address_output
    );

    modport slave (
        input  r_input, r_write, r_backup, r_restore,
        input  page_input, page_write, compare_input, compare_write,
        input  stack_pointer_input, stack_pointer_write,
        input  return_address_input, return_address_write,
        input  interrupt_input, interrupt_write,
        output r_output, flag_output, stack_pointer_output, return_address_output
    );

endinterface

`default_nettype wire

// File: rtl/register_file_en_reg.sv
// en_reg: WIDTH-bit register with load enable and synchronous active-low clear.
// Revision: 1.0
`default_nettype none

module en_reg #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// register_file: accumulator with backup/restore shadow, packed flags word,
// stack pointer and return address; every output is a flop.
// Revision: 1.0
`default_nettype none

module register_file
    import register_file_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    register_file_if.slave    bus
);

    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] acc_q;
    logic              acc_en;
    logic [DATA_W-1:0] backup_q;
    logic [PAGE_W-1:0] page_q;
    logic [INT_W-1:0]  intr_q;
    logic [CMP_W-1:0]  cmp_q;
    logic [DATA_W-1:0] sp_q;
    logic [DATA_W-1:0] ra_q;

    // Write wins over restore; restore takes the backup as it was before this edge.
    always_comb begin
        acc_en = bus.r_write | bus.r_restore;
        acc_d  = backup_q;
        if (bus.r_write) begin
            acc_d = bus.r_input;
        end
    end

    en_reg #(.WIDTH(DATA_W)) u_acc (
        .clk(clk), .rst_n(rst_n), .en(acc_en), .d(acc_d), .q(acc_q)
    );

    en_reg #(.WIDTH(DATA_W)) u_backup (
        .clk(clk), .rst_n(rst_n), .en(bus.r_backup), .d(bus.r_input), .q(backup_q)
    );

    en_reg #(.WIDTH(PAGE_W)) u_page (
        .clk(clk), .rst_n(rst_n), .en(bus.page_write), .d(bus.page_input), .q(page_q)
    );

    en_reg #(.WIDTH(INT_W)) u_intr (
        .clk(clk), .rst_n(rst_n), .en(bus.interrupt_write), .d(bus.interrupt_input), .q(intr_q)
    );

    en_reg #(.WIDTH(CMP_W)) u_cmp (
        .clk(clk), .rst_n(rst_n), .en(bus.compare_write), .d(bus.compare_input), .q(cmp_q)
    );

    en_reg #(.WIDTH(DATA_W)) u_sp (
        .clk(clk), .rst_n(rst_n), .en(bus.stack_pointer_write),
        .d(bus.stack_pointer_input), .q(sp_q)
    );

    en_reg #(.WIDTH(DATA_W)) u_ra (
        .clk(clk), .rst_n(rst_n), .en(bus.return_address_write),
        .d(bus.return_address_input), .q(ra_q)
    );

    assign bus.r_output              = acc_q;
    assign bus.flag_output           = pack_flags(page_q, intr_q, cmp_q);
    assign bus.stack_pointer_output  = sp_q;
    assign bus.return_address_output = ra_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// tb_register_file: vector table plus randomized model run against register_file,
// with expected outputs queued at drive time and compared after the edge.
`default_nettype none

module tb_register_file;

    logic clk;
    logic rst_n;
    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wr, bk, rs;
        logic [15:0] rin;
        logic [3:0]  pg;  logic pw;
        logic [2:0]  cm;  logic cw;
        logic [8:0]  it;  logic iw;
        logic [15:0] sp;  logic sw;
        logic [15:0] ra;  logic aw;
        logic [15:0] e_r, e_f, e_sp, e_ra;
    } vec_t;

    typedef struct {
        logic [15:0] r, f, sp, ra;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[29];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] m_acc, m_bk, m_sp, m_ra;
    logic [3:0]  m_pg;
    logic [8:0]  m_it;
    logic [2:0]  m_cm;

    function automatic int F(int p, int i, int c);
        return p * 4096 + i * 8 + c;
    endfunction

    function automatic vec_t V(int rst, int wr, int bk, int rs, int rin,
                               int pg, int pw, int cm, int cw, int it, int iw,
                               int sp, int sw, int ra, int aw,
                               int er, int ef, int esp, int era);
        vec_t v;
        v.rst_n = 1'(rst); v.wr = 1'(wr); v.bk = 1'(bk); v.rs = 1'(rs);
        v.rin = 16'(rin);
        v.pg = 4'(pg);  v.pw = 1'(pw);
        v.cm = 3'(cm);  v.cw = 1'(cw);
        v.it = 9'(it);  v.iw = 1'(iw);
        v.sp = 16'(sp); v.sw = 1'(sw);
        v.ra = 16'(ra); v.aw = 1'(aw);
        v.e_r = 16'(er); v.e_f = 16'(ef); v.e_sp = 16'(esp); v.e_ra = 16'(era);
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst_n                    = v.rst_n;
        bus.r_input              = v.rin;
        bus.r_write              = v.wr;
        bus.r_backup             = v.bk;
        bus.r_restore            = v.rs;
        bus.page_input           = v.pg;
        bus.page_write           = v.pw;
        bus.compare_input        = v.cm;
        bus.compare_write        = v.cw;
        bus.interrupt_input      = v.it;
        bus.interrupt_write      = v.iw;
        bus.stack_pointer_input  = v.sp;
        bus.stack_pointer_write  = v.sw;
        bus.return_address_input = v.ra;
        bus.return_address_write = v.aw;
    endtask

    // Drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e, g;
        @(negedge clk);
        drive(v);
        e.r = v.e_r; e.f = v.e_f; e.sp = v.e_sp; e.ra = v.e_ra;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk({tag, " r_output"},              bus.r_output,              g.r);
        chk({tag, " flag_output"},           bus.flag_output,           g.f);
        chk({tag, " stack_pointer_output"},  bus.stack_pointer_output,  g.sp);
        chk({tag, " return_address_output"}, bus.return_address_output, g.ra);
    endtask

    initial begin
        vec_t v;
        drive(V(1, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

        //          rst wr bk rs rin  pg pw cm cw it iw  sp sw  ra aw   r  flag           sp  ra
        tbl[0]  = V(0, 0,0,0, 0,   0,0, 0,0, 0,0,   0,0,   0,0,   0, F(0,0,0),      0,  0);
        tbl[1]  = V(1, 1,0,0, 5,   0,0, 0,0, 0,0,   0,0,   0,0,   5, F(0,0,0),      0,  0);
        tbl[2]  = V(1, 0,1,0, 3,   0,0, 0,0, 0,0,   0,0,   0,0,   5, F(0,0,0),      0,  0);
        tbl[3]  = V(1, 0,1,0, 2,   0,0, 0,0, 0,0,   0,0,   0,0,   5, F(0,0,0),      0,  0);
        tbl[4]  = V(1, 0,0,1, 0,   0,0, 0,0, 0,0,   0,0,   0,0,   2, F(0,0,0),      0,  0);
        tbl[5]  = V(1, 1,0,0, 7,   0,0, 0,0, 0,0,   0,0,   0,0,   7, F(0,0,0),      0,  0);
        tbl[6]  = V(1, 0,0,0, 0,   2,1, 0,0, 0,0,   0,0,   0,0,   7, F(2,0,0),      0,  0);
        tbl[7]  = V(1, 0,0,0, 0,   3,0, 0,0, 0,0,   0,0,   0,0,   7, F(2,0,0),      0,  0);
        tbl[8]  = V(1, 0,0,0, 0,   5,1, 0,0, 0,0,   0,0,   0,0,   7, F(5,0,0),      0,  0);
        tbl[9]  = V(1, 0,0,0, 0,   0,0, 2,1, 0,0,   0,0,   0,0,   7, F(5,0,2),      0,  0);
        tbl[10] = V(1, 0,0,0, 0,   0,0, 3,0, 0,0,   0,0,   0,0,   7, F(5,0,2),      0,  0);
        tbl[11] = V(1, 0,0,0, 0,   0,0, 5,1, 0,0,   0,0,   0,0,   7, F(5,0,5),      0,  0);
        tbl[12] = V(1, 0,0,0, 0,   0,0, 0,0, 23,1,  0,0,   0,0,   7, F(5,23,5),     0,  0);
        tbl[13] = V(1, 0,0,0, 0,   0,0, 0,0, 47,0,  0,0,   0,0,   7, F(5,23,5),     0,  0);
        tbl[14] = V(1, 0,0,0, 0,   0,0, 0,0, 35,1,  0,0,   0,0,   7, F(5,35,5),     0,  0);
        tbl[15] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   45,1,  0,0,   7, F(5,35,5),    45,  0);
        tbl[16] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   21,0,  0,0,   7, F(5,35,5),    45,  0);
        tbl[17] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   39,1,  0,0,   7, F(5,35,5),    39,  0);
        tbl[18] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   0,0, 111,1,   7, F(5,35,5),    39,111);
        tbl[19] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   0,0,  25,0,   7, F(5,35,5),    39,111);
        tbl[20] = V(1, 0,0,0, 0,   0,0, 0,0, 0,0,   0,0,  24,1,   7, F(5,35,5),    39, 24);
        tbl[21] = V(1, 1,0,1, 9,   0,0, 0,0, 0,0,   0,0,   0,0,   9, F(5,35,5),    39, 24);
        tbl[22] = V(1, 0,1,0, 4,   0,0, 0,0, 0,0,   0,0,   0,0,   9, F(5,35,5),    39, 24);
        tbl[23] = V(1, 0,1,1, 6,   0,0, 0,0, 0,0,   0,0,   0,0,   4, F(5,35,5),    39, 24);
        tbl[24] = V(1, 0,0,1, 0,   0,0, 0,0, 0,0,   0,0,   0,0,   6, F(5,35,5),    39, 24);
        tbl[25] = V(1, 1,1,0, 8,   0,0, 0,0, 0,0,   0,0,   0,0,   8, F(5,35,5),    39, 24);
        tbl[26] = V(1, 0,0,1, 0,   0,0, 0,0, 0,0,   0,0,   0,0,   8, F(5,35,5),    39, 24);
        tbl[27] = V(0, 1,1,1, 16'h1234, 15,1, 7,1, 511,1, 16'hBEEF,1, 16'hCAFE,1,
                    0, F(0,0,0), 0, 0);
        tbl[28] = V(1, 0,0,1, 0,   0,0, 0,0, 0,0,   0,0,   0,0,   0, F(0,0,0),      0,  0);

        for (int i = 0; i < 29; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Inputs must not reach outputs before the edge.
        @(negedge clk);
        v = V(1, 1,1,0, 16'hAAAA, 9,1, 6,1, 300,1, 16'h5555,1, 16'h3333,1, 0,0,0,0);
        drive(v);
        #1;
        chk("comb_path r_output",    bus.r_output,              16'h0000);
        chk("comb_path flag_output", bus.flag_output,           16'h0000);
        chk("comb_path sp",          bus.stack_pointer_output,  16'h0000);
        chk("comb_path ra",          bus.return_address_output, 16'h0000);
        @(posedge clk);
        #1;
        chk("latch r_output",    bus.r_output,              16'hAAAA);
        chk("latch flag_output", bus.flag_output,           16'(F(9,300,6)));
        chk("latch sp",          bus.stack_pointer_output,  16'h5555);
        chk("latch ra",          bus.return_address_output, 16'h3333);

        m_acc = 16'hAAAA; m_bk = 16'hAAAA; m_pg = 4'd9; m_it = 9'd300; m_cm = 3'd6;
        m_sp = 16'h5555; m_ra = 16'h3333;

        for (int k = 0; k < 3; k++) begin
            v = V(1, 0,0,0, 16'hFFFF, 15,0, 7,0, 511,0, 16'hFFFF,0, 16'hFFFF,0,
                  int'(m_acc), F(int'(m_pg), int'(m_it), int'(m_cm)), int'(m_sp), int'(m_ra));
            step(v, $sformatf("hold%0d", k));
        end

        // Randomized run against a behavioural model of the register file.
        for (int k = 0; k < 60; k++) begin
            v.rst_n = ($urandom_range(0, 15) != 0);
            v.wr  = 1'($urandom); v.bk = 1'($urandom); v.rs = 1'($urandom);
            v.rin = 16'($urandom);
            v.pg  = 4'($urandom); v.pw = 1'($urandom);
            v.cm  = 3'($urandom); v.cw = 1'($urandom);
            v.it  = 9'($urandom); v.iw = 1'($urandom);
            v.sp  = 16'($urandom); v.sw = 1'($urandom);
            v.ra  = 16'($urandom); v.aw = 1'($urandom);
            if (!v.rst_n) begin
                m_acc = '0; m_bk = '0; m_pg = '0; m_it = '0; m_cm = '0; m_sp = '0; m_ra = '0;
            end else begin
                if (v.wr)      m_acc = v.rin;
                else if (v.rs) m_acc = m_bk;
                if (v.bk) m_bk = v.rin;
                if (v.pw) m_pg = v.pg;
                if (v.iw) m_it = v.it;
                if (v.cw) m_cm = v.cm;
                if (v.sw) m_sp = v.sp;
                if (v.aw) m_ra = v.ra;
            end
            v.e_r = m_acc; v.e_f = {m_pg, m_it, m_cm}; v.e_sp = m_sp; v.e_ra = m_ra;
            step(v, $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
